// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, next-PC
// select codes, trap cause codes and the NOP instruction word.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_EXEC,
    ST_HALTED,
    ST_TRAPPED
  } seq_state_t;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;
  localparam logic [1:0] PCSRC_RSVD   = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection and alignment check (purely combinational).
// Ports:
//   pc          - current program counter
//   pc_src      - select: PLUS4 / BRANCH / JALR / reserved
//   pc_target   - branch/JAL target
//   jalr_target - JALR target (bit 0 is cleared here)
//   next_pc     - selected next PC (pc when pc_src is reserved)
//   misaligned  - selected next PC is not word aligned
//   illegal     - pc_src is the reserved code
module next_pc_sel
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] pc_target,
  input  logic [31:0] jalr_target,
  output logic [31:0] next_pc,
  output logic        misaligned,
  output logic        illegal
);

  always_comb begin
    next_pc = pc;
    illegal = 1'b0;
    case (pc_src)
      PCSRC_PLUS4:  next_pc = pc + 32'd4;
      PCSRC_BRANCH: next_pc = pc_target;
      PCSRC_JALR:   next_pc = jalr_target & ~32'd1;
      default:      illegal = 1'b1;
    endcase
  end

  assign misaligned = !illegal && (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction at a time from
// instruction memory, hands it to the datapath, and advances the PC when
// the datapath commits. Traps (sticky) on misaligned target, fetch timeout
// or illegal pc_src; halts on request.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   imem_req/imem_addr         - fetch request and address (= pc)
//   imem_ack/imem_rdata        - fetch completion and instruction word
//   instr/instr_valid          - latched instruction and one-cycle execute pulse
//   exec_done                  - datapath committed the current instruction
//   pc_src/pc_target/jalr_target - next-PC select and candidate targets
//   halt                       - stop after the current instruction commits
//   pc, trap, trap_cause, retired - architectural status
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [1:0]  pc_src,
  input  logic [31:0] pc_target,
  input  logic [31:0] jalr_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired
);

  localparam int unsigned WAIT_W = $clog2(WAIT_LIMIT + 1);

  seq_state_t        state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       retired_q, retired_d;
  logic              instr_valid_q, instr_valid_d;
  logic              trap_q, trap_d;
  logic [1:0]        cause_q, cause_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [31:0] sel_pc;
  logic        sel_misaligned;
  logic        sel_illegal;

  next_pc_sel u_next_pc_sel (
    .pc          (pc_q),
    .pc_src      (pc_src),
    .pc_target   (pc_target),
    .jalr_target (jalr_target),
    .next_pc     (sel_pc),
    .misaligned  (sel_misaligned),
    .illegal     (sel_illegal)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    trap_d        = trap_q;
    cause_d       = cause_q;
    retired_d     = retired_q;
    wait_d        = '0;
    imem_req      = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = ST_EXEC;
        end else if (wait_q == WAIT_W'(WAIT_LIMIT - 1)) begin
          // this cycle is the WAIT_LIMIT-th one without ack
          state_d = ST_TRAPPED;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_EXEC: begin
        if (exec_done) begin
          if (sel_illegal) begin
            state_d = ST_TRAPPED;
            trap_d  = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            // a misaligned target still retires the instruction, but keeps pc
            retired_d = retired_q + 32'd1;
            if (sel_misaligned) begin
              state_d = ST_TRAPPED;
              trap_d  = 1'b1;
              cause_d = CAUSE_MISALIGN;
            end else begin
              pc_d    = sel_pc;
              state_d = halt ? ST_HALTED : ST_FETCH;
            end
          end
        end
      end

      ST_HALTED, ST_TRAPPED: ;

      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      trap_q        <= 1'b0;
      cause_q       <= CAUSE_NONE;
      retired_q     <= '0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      trap_q        <= trap_d;
      cause_q       <= cause_d;
      retired_q     <= retired_d;
      wait_q        <= wait_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized fetch/execute transactions against a transaction-level model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned WAIT_LIMIT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic [1:0]  pc_src;
  logic [31:0] pc_target;
  logic [31:0] jalr_target;
  logic        halt;
  logic [31:0] pc;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(RESET_PC), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .pc_src      (pc_src),
    .pc_target   (pc_target),
    .jalr_target (jalr_target),
    .halt        (halt),
    .pc          (pc),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .retired     (retired)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // transaction-level model: m_term 0 = running, 1 = halted, 2 = trapped
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [31:0] m_instr;
  logic [1:0]  m_cause;
  int          m_term;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_pc"},    pc,         m_pc);
    check({tag, "_ret"},   retired,    m_ret);
    check({tag, "_trap"},  trap,       32'(m_term == 2));
    check({tag, "_cause"}, trap_cause, 32'(m_cause));
  endtask

  task automatic do_reset(input logic late_ack);
    @(negedge clk);
    rst_n      = 1'b0;
    exec_done  = 1'b0;
    halt       = 1'b0;
    pc_src     = PCSRC_PLUS4;
    imem_ack   = late_ack;
    imem_rdata = $urandom;
    m_pc = RESET_PC; m_ret = '0; m_cause = CAUSE_NONE; m_term = 0; m_instr = 32'h0000_0013;
    #1;
    check_status("rst");
    check("rst_req",   imem_req,    0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr,       32'h0000_0013);
    @(negedge clk);
    rst_n = 1'b1;
    check("boot_req", imem_req, 0);
    @(negedge clk);
    imem_ack = 1'b0;
    check("boot_ack_ignored_valid", instr_valid, 0);
    check("boot_ack_ignored_instr", instr,       32'h0000_0013);
    check("fetch_req_after_boot",   imem_req,    1);
  endtask

  task automatic fetch(input int waits, input logic [31:0] word);
    imem_ack = 1'b0;
    for (int i = 0; i < waits; i++) begin
      check("fetch_wait_req",  imem_req,  1);
      check("fetch_wait_addr", imem_addr, m_pc);
      @(negedge clk);
    end
    check("fetch_req",  imem_req,  1);
    check("fetch_addr", imem_addr, m_pc);
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    m_instr    = word;
    check("valid_pulse", instr_valid, 1);
    check("instr_latch", instr,       word);
    check("exec_req",    imem_req,    0);
  endtask

  task automatic exec(input int delay, input logic [1:0] src, input logic [31:0] tgt,
                      input logic [31:0] jtgt, input logic hlt);
    logic [31:0] nxt;
    for (int i = 0; i < delay; i++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
      check("exec_valid_once", instr_valid, 0);
      check("exec_instr_hold", instr,       m_instr);
      check("exec_wait_req",   imem_req,    0);
    end
    exec_done   = 1'b1;
    pc_src      = src;
    pc_target   = tgt;
    jalr_target = jtgt;
    halt        = hlt;
    @(negedge clk);
    exec_done = 1'b0;
    imem_ack  = 1'b0;
    halt      = 1'b0;

    if (src == 2'd3) begin
      m_term  = 2;
      m_cause = 2'b11;
    end else begin
      case (src)
        2'd0:    nxt = m_pc + 32'd4;
        2'd1:    nxt = tgt;
        default: nxt = jtgt - (jtgt % 2);
      endcase
      m_ret = m_ret + 32'd1;
      if (nxt % 4 != 0) begin
        m_term  = 2;
        m_cause = 2'b01;
      end else begin
        m_pc   = nxt;
        m_term = hlt ? 1 : 0;
      end
    end
    check_status("commit");
    check("commit_req",   imem_req,    32'(m_term == 0));
    check("commit_valid", instr_valid, 0);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack  = 1'($urandom_range(0, 1));
      exec_done = 1'($urandom_range(0, 1));
      pc_src    = 2'($urandom_range(0, 3));
      @(negedge clk);
      check("idle_req",   imem_req,    0);
      check("idle_valid", instr_valid, 0);
      check_status("idle");
    end
    imem_ack  = 1'b0;
    exec_done = 1'b0;
  endtask

  initial begin
    int          w;
    logic [1:0]  src;
    logic [31:0] tgt, jt;
    logic        hlt;

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
    pc_src = '0; pc_target = '0; jalr_target = '0; halt = 1'b0;

    // basic fetch/commit from reset
    do_reset(1'b0);
    fetch(1, 32'h0000_0093);
    exec(0, PCSRC_PLUS4, 32'h0, 32'h0, 1'b0);
    fetch(0, 32'h0010_0113);
    exec(1, PCSRC_PLUS4, 32'h0, 32'h0, 1'b0);
    // branch and jalr targets
    fetch(0, $urandom);
    exec(2, PCSRC_BRANCH, 32'h0000_0100, 32'h0, 1'b0);
    fetch(0, $urandom);
    exec(1, PCSRC_JALR, 32'h0, 32'h0000_0205, 1'b0);
    // pc+4 wraps at the top of the address space
    fetch(0, $urandom);
    exec(0, PCSRC_BRANCH, 32'hFFFF_FFFC, 32'h0, 1'b0);
    fetch(0, $urandom);
    exec(0, PCSRC_PLUS4, 32'h0, 32'h0, 1'b0);
    // misaligned target traps
    fetch(0, $urandom);
    exec(0, PCSRC_BRANCH, 32'h0000_0102, 32'h0, 1'b0);
    idle_check(3);

    // fetch timeout at exactly WAIT_LIMIT wait cycles
    do_reset(1'b0);
    for (int i = 0; i < int'(WAIT_LIMIT); i++) begin
      check("timeout_pre_req",  imem_req, 1);
      check("timeout_pre_trap", trap,     0);
      @(negedge clk);
    end
    m_term = 2; m_cause = 2'b10;
    check_status("timeout");
    check("timeout_req", imem_req, 0);
    idle_check(2);

    // halt, then reset
    do_reset(1'b0);
    fetch(2, $urandom);
    exec(1, PCSRC_PLUS4, 32'h0, 32'h0, 1'b1);
    idle_check(3);

    // halt coinciding with misalignment traps instead
    do_reset(1'b0);
    fetch(0, $urandom);
    exec(0, PCSRC_JALR, 32'h0, 32'h0000_0042, 1'b1);
    idle_check(2);

    // reserved pc_src
    do_reset(1'b0);
    fetch(0, $urandom);
    exec(0, PCSRC_RSVD, 32'h0000_0040, 32'h0000_0040, 1'b0);
    idle_check(2);

    // reset mid-exec and mid-fetch with a lingering ack
    do_reset(1'b0);
    fetch(0, $urandom);
    do_reset(1'b1);
    do_reset(1'b1);

    // retired wraps
    fetch(0, $urandom);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m_ret = 32'hFFFF_FFFF;
    check("force_ret", retired, m_ret);
    exec(0, PCSRC_PLUS4, 32'h0, 32'h0, 1'b0);

    // randomized transactions
    for (int k = 0; k < 60; k++) begin
      if (m_term != 0) do_reset(1'($urandom_range(0, 1)));
      w = ($urandom_range(0, 3) == 0) ? int'(WAIT_LIMIT) - 1 : int'($urandom_range(0, 3));
      fetch(w, $urandom);
      src = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      jt = $urandom;
      if ($urandom_range(0, 7) != 0) jt[1] = 1'b0;
      hlt = ($urandom_range(0, 9) == 0);
      exec(int'($urandom_range(0, 3)), src, tgt, jt, hlt);
      if (m_term != 0) idle_check(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter WAIT_LIMIT, default 16, the maximum number of fetch-wait cycles before a fetch timeout.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  32  fetch address, equal to pc.
REQ-007 imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 instr  out  32  latched instruction presented to the datapath.
REQ-010 instr_valid  out  1  one-cycle pulse: the datapath may execute instr.
REQ-011 exec_done  in  1  the datapath has committed the current instruction.
REQ-012 pc_src  in  2  next-PC select: 00 = pc+4, 01 = pc_target, 10 = jalr_target, 11 = reserved.
REQ-013 pc_target  in  32  branch/JAL target from the PC-target adder.
REQ-014 jalr_target  in  32  JALR target from the ALU result.
REQ-015 halt  in  1  stop after the current instruction commits.
REQ-016 pc  out  32  current program counter.
REQ-017 trap  out  1  sticky error flag.
REQ-018 trap_cause  out  2  error cause: 01 = misaligned target, 10 = fetch timeout, 11 = illegal pc_src.
REQ-019 retired  out  32  count of committed instructions.

Function
REQ-020 SHALL implement FSM states BOOT, FETCH, EXEC, HALTED, TRAPPED.
REQ-021 BOOT SHALL last exactly one cycle after reset release and then go to FETCH.
REQ-022 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ack.
REQ-023 On imem_ack in FETCH, the FSM SHALL latch imem_rdata into instr, pulse instr_valid in the next cycle, and enter EXEC; fetch latency is therefore at least 2 cycles.
REQ-024 imem_ack outside FETCH SHALL be ignored.
REQ-025 A wait counter SHALL count FETCH cycles without ack; reaching WAIT_LIMIT SHALL enter TRAPPED with cause 10.
REQ-026 In EXEC, imem_req SHALL be 0, and the FSM SHALL wait for exec_done for an unbounded time.
REQ-027 On exec_done, the next PC SHALL be: pc+4 (mod 2^32) for 00; pc_target for 01; {jalr_target[31:1],1'b0} for 10.
REQ-028 pc_src = 11 on exec_done SHALL enter TRAPPED with cause 11; pc SHALL be unchanged and retired SHALL NOT increment.
REQ-029 If the selected next PC has [1:0] != 00, the FSM SHALL enter TRAPPED with cause 01; pc SHALL be unchanged and retired SHALL increment.
REQ-030 Otherwise, on exec_done, pc SHALL load the next PC and retired SHALL increment, wrapping from 32'hFFFF_FFFF to 0.
REQ-031 After a committed instruction, if halt = 1 in the exec_done cycle the FSM SHALL enter HALTED, else FETCH.
REQ-032 If a misalignment and halt coincide, the trap SHALL take priority.
REQ-033 HALTED and TRAPPED SHALL be terminal until reset; imem_req and instr_valid SHALL be 0 in both.
REQ-034 The trap flag SHALL be set only on entry to TRAPPED.

Reset
REQ-035 On rst_n = 0, asynchronously: state = BOOT, pc = RESET_PC, instr = 32'h0000_0013 (NOP), instr_valid = 0, imem_req = 0, trap = 0, trap_cause = 00, retired = 0, wait counter = 0.
REQ-036 Reset mid-fetch or mid-exec SHALL abandon the operation, and a late imem_ack after reset release SHALL be ignored until FETCH.

Structure
REQ-037 The shared package SHALL hold the state encoding, the pc_src codes (PCSRC_PLUS4, PCSRC_BRANCH, PCSRC_JALR), the trap_cause codes and the NOP constant.
REQ-038 The next-PC selection and alignment check SHALL be one combinational sub-module, next_pc_sel; the FSM, counters and registers stay in pc_sequencer.

Verification
REQ-039 Reset release with ack after 1 wait cycle: imem_addr = 0; instr_valid pulses; exec_done with pc_src = 00 -> pc = 4, retired = 1.
REQ-040 pc = 8, pc_src = 01, pc_target = 32'h100 -> next fetch at 32'h100; pc_src = 10, jalr_target = 32'h205 -> pc = 32'h204.
REQ-041 pc_src = 01, pc_target = 32'h102 -> trap = 1, cause = 01, pc unchanged, imem_req stays 0.
REQ-042 Withhold imem_ack for 16 cycles -> TRAPPED with cause 10 at the 16th wait cycle.
REQ-043 halt = 1 with exec_done -> pc updated, retired incremented, no further imem_req; assert rst_n = 0 -> pc = RESET_PC, retired = 0.
REQ-044 Preload retired to 32'hFFFF_FFFF by forcing, then commit one instruction -> retired = 0.
